digit_entry: RTL

Parametrised keypad-entry register for the FPGA template: synchronises the pushbuttons, detects key presses, shifts hex or decimal digits into an N-digit entry buffer, and supports backspace, clear and enter. Its `digits`/`flt_pt` outputs feed the `seven_seg` decoder directly. On enter it captures the value for downstream logic with a one-cycle valid pulse.

---
 rtl/digit_entry_pkg.sv | 31 +++
 rtl/digit_entry_sync_edge.sv | 42 ++++
 rtl/digit_entry.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the keypad digit-entry register.
// The optional blinking cursor is selected with DIGIT_ENTRY_BLINK_EN.
package digit_entry_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    FULL,
    SHOW
  } entry_state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_DIGIT,
    ACT_BKSP,
    ACT_ENTER,
    ACT_CLEAR
  } entry_act_t;

  localparam logic [15:0] DEC_KEY_MASK = 16'h03FF;

  function automatic logic [3:0] key_index(input logic [15:0] keys);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (keys[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/digit_entry_sync_edge.sv
// Two-flop synchroniser with a previous-sample register and rising-edge detect.
// Part of digit_entry (optional cursor blink: DIGIT_ENTRY_BLINK_EN, unused here).
import digit_entry_pkg::*;

module sync_edge #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         NRST,
  input  logic [W-1:0] din,
  output logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;
  logic [W-1:0] prev_q;
  logic [W-1:0] armed_q;
  logic [1:0]   fill_q;

  // An input only arms once the pipeline holds real samples and has seen it low,
  // so a key held through reset release never looks like a fresh press.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      fill_q  <= '0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | ({W{fill_q[1]}} & ~s2_q);
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q & armed_q;

endmodule

// File: rtl/digit_entry.sv
// Keypad entry register: synchronised key edges drive a shift buffer FSM.
// Define DIGIT_ENTRY_BLINK_EN for a blinking cursor; otherwise it is steady.
import digit_entry_pkg::*;

module digit_entry #(
  parameter int NDIGITS   = 8,
  parameter int BLINK_DIV = 50,
  localparam int CW       = $clog2(NDIGITS + 1)
) (
  input  logic                      CLK,
  input  logic                      NRST,
  input  logic [15:0]               pb,
  input  logic                      bksp,
  input  logic                      clear,
  input  logic                      enter,
  input  logic                      mode_dec,
  output logic [NDIGITS-1:0][3:0]   digits,
  output logic [NDIGITS-1:0]        blank,
  output logic [NDIGITS-1:0]        flt_pt,
  output logic [CW-1:0]             count,
  output logic [4*NDIGITS-1:0]      value,
  output logic                      value_valid
);

  localparam logic [CW-1:0]      ONE_CNT   = CW'(1);
  localparam logic [CW-1:0]      FULL_CNT  = CW'(NDIGITS);
  localparam logic [NDIGITS-1:0] BLANK_RST = {NDIGITS{1'b1}} << 1;

  logic [19:0] raw_in;
  logic [19:0] sync_level;
  logic [19:0] sync_rise;
  logic        sync_unused;

  assign raw_in = {mode_dec, enter, clear, bksp, pb};

  sync_edge #(.W(20)) u_sync (
    .CLK   (CLK),
    .NRST  (NRST),
    .din   (raw_in),
    .level (sync_level),
    .rise  (sync_rise)
  );

  assign sync_unused = ^{sync_level[18:0], sync_rise[19]};

  logic [15:0]  dig_edges;
  logic         dec_mode;
  entry_act_t   act;

  assign dec_mode  = sync_level[19];
  assign dig_edges = sync_rise[15:0] & (dec_mode ? DEC_KEY_MASK : 16'hFFFF);

  always_comb begin
    act = ACT_NONE;
    if (sync_rise[17])         act = ACT_CLEAR;
    else if (sync_rise[16])    act = ACT_BKSP;
    else if (sync_rise[18])    act = ACT_ENTER;
    else if ($onehot(dig_edges)) act = ACT_DIGIT;
  end

  entry_state_t               state_q, state_d;
  logic [NDIGITS-1:0][3:0]    digits_q, digits_d, dig_src;
  logic [CW-1:0]              count_q, count_d, cnt_src;
  logic [4*NDIGITS-1:0]       value_q, value_d;
  logic                       valid_q, valid_d;
  logic [NDIGITS-1:0]         blank_q, blank_d;
  logic                       cursor_q;

  // A digit typed while a result is shown starts a fresh entry.
  assign dig_src = (state_q == SHOW) ? '0 : digits_q;
  assign cnt_src = (state_q == SHOW) ? '0 : count_q;

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    case (act)
      ACT_CLEAR: begin
        digits_d = '0;
        count_d  = '0;
        state_d  = EMPTY;
      end
      ACT_BKSP: begin
        if (state_q == SHOW) begin
          digits_d = '0;
          count_d  = '0;
          state_d  = EMPTY;
        end else if (state_q != EMPTY) begin
          for (int i = 0; i < NDIGITS - 1; i++) digits_d[i] = digits_q[i+1];
          digits_d[NDIGITS-1] = 4'd0;
          count_d = count_q - ONE_CNT;
          state_d = (count_q == ONE_CNT) ? EMPTY : ENTRY;
        end
      end
      ACT_ENTER: begin
        if (state_q == ENTRY || state_q == FULL) begin
          value_d = digits_q;
          valid_d = 1'b1;
          state_d = SHOW;
        end
      end
      ACT_DIGIT: begin
        if (state_q != FULL) begin
          for (int i = NDIGITS - 1; i > 0; i--) digits_d[i] = dig_src[i-1];
          digits_d[0] = key_index(dig_edges);
          count_d = cnt_src + ONE_CNT;
          state_d = (count_d == FULL_CNT) ? FULL : ENTRY;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    blank_d = '0;
    for (int i = 0; i < NDIGITS; i++) blank_d[i] = (i >= int'(count_d));
    if (state_d == EMPTY) blank_d[0] = 1'b0;
    if (state_d == SHOW)  blank_d    = '0;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q  <= EMPTY;
      digits_q <= '0;
      count_q  <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      blank_q  <= BLANK_RST;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
    end
  end

`ifdef DIGIT_ENTRY_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_q;

  // The counter parks at zero with the cursor dark whenever entry is not possible.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      blink_q  <= '0;
      cursor_q <= 1'b0;
    end else if (state_d == FULL || state_d == SHOW) begin
      blink_q  <= '0;
      cursor_q <= 1'b0;
    end else if (state_q == EMPTY || state_q == ENTRY) begin
      if (blink_q == BLINK_TOP) begin
        blink_q  <= '0;
        cursor_q <= ~cursor_q;
      end else begin
        blink_q <= blink_q + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) cursor_q <= 1'b0;
    else       cursor_q <= (state_d == EMPTY || state_d == ENTRY);
  end
`endif

  always_comb begin
    flt_pt    = '0;
    flt_pt[0] = cursor_q;
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign count       = count_q;
  assign value       = value_q;
  assign value_valid = valid_q;

endmodule
